conv3x3_filter_engine: RTL
==========================

Name: conv3x3_filter_engine

Overview:
Parametrised 3x3 neighbourhood filter for the camera pixel stream. Sits after the grayscale stage and before display/frame-buffer write-back. Generalises the fixed Sobel-magnitude stage with configurable data width and line length, four runtime-selectable kernel modes latched per frame, and deterministic zeroing of border/warm-up pixels. Fixed 3-cycle latency; one output per accepted input pixel.

Parameters:
DATA_W, 12, pixel width in bits (input and output).
LINE_W, 1280, maximum pixels per line; sets depth of each of the two line buffers.
COORD_W, 16, width of the X/Y coordinate ports.

Ports:
iCLK  in  1  clock; all logic on rising edge.
iRST  in  1  synchronous, active-low reset.
iMODE  in  2  kernel select: 0 pass, 1 Sobel magnitude, 2 Gaussian, 3 Sobel threshold; latched at frame start.
iTHRESH  in  DATA_W  threshold for mode 3; sampled live.
iDATA  in  DATA_W  input pixel.
iDVAL  in  1  input pixel valid.
iX_Cont  in  COORD_W  input column.
iY_Cont  in  COORD_W  input row.
oDATA  out  DATA_W  filtered pixel.
oDVAL  out  1  output valid.
oX_Cont  out  COORD_W  column of the input pixel that produced this output.
oY_Cont  out  COORD_W  row of the input pixel that produced this output.

Behaviour:
- Reset (iRST=0 at a clock edge): oDVAL=0, oDATA=0, oX_Cont=0, oY_Cont=0, mode register=0, all pipeline valids=0. Line-buffer RAM is not cleared. Reset mid-frame discards in-flight pixels; the next output appears 3 cycles after the next accepted pixel.
- Accept: iDVAL=1 and iX_Cont<LINE_W. A pixel with iX_Cont>=LINE_W is dropped: no RAM write, no output.
- Frame start: an accepted pixel with X=0, Y=0 loads the mode register from iMODE, and that pixel already uses the new mode. iMODE changes at any other time are ignored until the next frame start.
- Window: on each accepted pixel, read row y-1 and row y-2 at address X, write iDATA at X, and shift the three 3-tap column registers. The window's bottom-right is the current pixel; its centre is (X-1, Y-1).
- Pipeline:
  - S1: window/RAM read.
  - S2: kernel arithmetic, registered.
  - S3: mode select, clamp and border mask, registered.
  - oDVAL is the accepted-pixel valid delayed exactly 3 cycles. Bubbles (iDVAL=0) propagate as oDVAL=0.
  - oDATA, oX_Cont and oY_Cont hold their last value while oDVAL=0.
- Border rule (all modes): if X<2 or Y<2, oDATA=0 with oDVAL=1. Row-buffer garbage never reaches the output.
- Arithmetic:
  - Gx and Gy use standard Sobel kernels, signed, DATA_W+4 bits.
  - Mode 1: (|Gx|+|Gy|)>>1, saturated to 2^DATA_W-1.
  - Mode 2: kernel weights 1 2 1 / 2 4 2 / 1 2 1, sum>>4, truncated (no clamp needed).
  - Mode 3: output all-ones if the mode-1 value >= iTHRESH, else 0.
  - Mode 0: centre pixel.
- Line wrap: buffer addresses are the raw iX_Cont, so there is no wrap counter. Shorter lines are allowed, and entries at unused columns are stale but masked or unused.
- iDVAL=0 in the same cycle as a frame-start coordinate: nothing happens.

Optional Feature:
Macro CONV_STATS_EN. When defined, add two outputs:
- oEDGE_CNT (out, 32): count of outputs this frame with oDVAL=1 and oDATA>iTHRESH.
- oSTATS_VLD (out, 1).

At the S3 output of each frame-start pixel:
- oEDGE_CNT is loaded with the completed frame's count.
- The counter restarts at 0. The frame-start pixel's own output is not counted, since it is a border pixel and always 0.
- oSTATS_VLD pulses for 1 cycle.

Both outputs reset to 0. When the macro is undefined, the ports and counter are absent and behaviour is otherwise identical.

Test Plan:
1. Reset held 5 cycles, then released with iDVAL=0 for 5 cycles -> oDVAL=0, oDATA=0; the first accepted pixel gives oDVAL=1 exactly 3 cycles later.
2. LINE_W=16, mode 1, 8 rows of uniform 200 with 4-cycle blanking -> 128 valid outputs, every oDATA=0; oX/oY match the inputs, in order.
3. LINE_W=16, mode 1, rows with 0 for X<8 and 255 for X>=8 -> oDATA=510 at oX=8 and 9 for oY>=2; 0 everywhere else. The same pattern with 4095 instead of 255 -> 4095 (clamped) at those positions.
4. Same step pattern at 255, mode 3, iTHRESH=300 -> 4095 at oX=8,9 for oY>=2, else 0. iTHRESH=600 -> all outputs 0.
5. Mode 2, uniform 200 -> 200 for X>=2, Y>=2, and 0 on the border. Changing iMODE from 2 to 1 at row 3 -> mode 2 holds until the next X=0, Y=0 pixel, after which interior outputs are 0.
6. With CONV_STATS_EN defined, frame 1 is the 255-step in mode 1 with iTHRESH=10 (LINE_W=16, 8 rows), then frame 2 starts -> oSTATS_VLD pulses once and oEDGE_CNT=12. Reset mid-frame -> oEDGE_CNT=0 and no pulse until the next frame start.

Source files
------------

// File: rtl/conv3x3_filter_engine_if.sv
// conv3x3_filter_engine_if: pixel stream bundle (data, valid, column, row) for the 3x3 filter
interface conv3x3_filter_engine_if #(
    parameter int DATA_W  = 12,
    parameter int COORD_W = 16
);
    logic [DATA_W-1:0]  data;
    logic               dval;
    logic [COORD_W-1:0] x_cont;
    logic [COORD_W-1:0] y_cont;

    modport master (output data, dval, x_cont, y_cont);
    modport slave  (input  data, dval, x_cont, y_cont);
endinterface

// File: rtl/conv3x3_filter_engine.sv
// conv3x3_filter_engine: 3-cycle 3x3 neighbourhood filter (pass/Sobel/Gaussian/threshold); CONV_STATS_EN adds per-frame edge statistics
module conv3x3_filter_engine #(
    parameter int DATA_W  = 12,
    parameter int LINE_W  = 1280,
    parameter int COORD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   thresh,
    conv3x3_filter_engine_if.slave  pix,
    conv3x3_filter_engine_if.master flt
`ifdef CONV_STATS_EN
    ,
    output logic [31:0]         edge_cnt,
    output logic                stats_vld
`endif
);
    localparam int W  = DATA_W + 4;
    localparam int AW = LINE_W > 1 ? $clog2(LINE_W) : 1;
    localparam logic [DATA_W-1:0] MAXV = '1;

    logic [DATA_W-1:0]  lb1 [LINE_W];
    logic [DATA_W-1:0]  lb2 [LINE_W];
    logic [DATA_W-1:0]  col [3][3];
    logic [AW-1:0]      addr;
    logic               accept, fstart;
    logic [1:0]         mode_r, cur_mode, m1, m2;
    logic               v1, v2;
    logic [COORD_W-1:0] x1, y1, x2, y2;
    logic [W-1:0]       a [3][3];
    logic signed [W-1:0] gx, gy;
    logic [W-1:0]       ax, ay, gsum, mag2, mag;
    logic [DATA_W-1:0]  gau2, ctr2, sat, res;

    assign addr     = pix.x_cont[AW-1:0];
    assign accept   = pix.dval && pix.x_cont < COORD_W'(LINE_W);
    assign fstart   = accept && pix.x_cont == '0 && pix.y_cont == '0;
    assign cur_mode = fstart ? mode : mode_r;

    // Line buffers: the row above slides down to two-rows-above as the current pixel replaces it
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[addr] <= pix.data;
            lb2[addr] <= lb1[addr];
        end
    end

    // S1: shift the window columns (newest column is rows y-2, y-1, y at X) and latch the frame mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            mode_r <= 2'd0;
        end else begin
            v1 <= accept;
            if (fstart) mode_r <= mode;
        end
        if (accept) begin
            col[2] <= col[1];
            col[1] <= col[0];
            col[0] <= '{lb2[addr], lb1[addr], pix.data};
            x1     <= pix.x_cont;
            y1     <= pix.y_cont;
            m1     <= cur_mode;
        end
    end

    // Kernel arithmetic on the window; a[row][col] with row 0 = y-2 and col 0 = x-2
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                a[r][k] = W'(col[2-k][r]);
        gx   = $signed(a[0][2] + (a[1][2] << 1) + a[2][2] - a[0][0] - (a[1][0] << 1) - a[2][0]);
        gy   = $signed(a[2][0] + (a[2][1] << 1) + a[2][2] - a[0][0] - (a[0][1] << 1) - a[0][2]);
        ax   = gx[W-1] ? -gx : gx;
        ay   = gy[W-1] ? -gy : gy;
        gsum = a[0][0] + a[0][2] + a[2][0] + a[2][2]
             + ((a[0][1] + a[1][0] + a[1][2] + a[2][1]) << 1) + (a[1][1] << 2);
    end

    // S2: register gradient magnitude sum, Gaussian result and centre pixel
    always_ff @(posedge clk) begin
        if (!rst_n) v2 <= 1'b0;
        else        v2 <= v1;
        if (v1) begin
            mag2 <= ax + ay;
            gau2 <= DATA_W'(gsum >> 4);
            ctr2 <= col[1][1];
            x2   <= x1;
            y2   <= y1;
            m2   <= m1;
        end
    end

    // Mode select with saturation; border positions are forced to zero so stale line data never escapes
    always_comb begin
        mag = mag2 >> 1;
        sat = mag > W'(MAXV) ? MAXV : mag[DATA_W-1:0];
        res = (x2 < COORD_W'(2) || y2 < COORD_W'(2)) ? '0 :
              m2 == 2'd0 ? ctr2 :
              m2 == 2'd1 ? sat  :
              m2 == 2'd2 ? gau2 :
              (sat >= thresh ? MAXV : '0);
    end

    // S3: output register; data and coordinates hold while no valid pixel emerges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flt.dval   <= 1'b0;
            flt.data   <= '0;
            flt.x_cont <= '0;
            flt.y_cont <= '0;
        end else begin
            flt.dval <= v2;
            if (v2) begin
                flt.data   <= res;
                flt.x_cont <= x2;
                flt.y_cont <= y2;
            end
        end
    end

`ifdef CONV_STATS_EN
    logic        f1, f2;
    logic [31:0] cnt;

    // Carry the frame-start tag alongside each pixel to the output stage
    always_ff @(posedge clk) begin
        if (accept) f1 <= fstart;
        if (v1)     f2 <= f1;
    end

    // Count above-threshold outputs; publish and restart at each frame-start output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            edge_cnt  <= '0;
            stats_vld <= 1'b0;
        end else begin
            stats_vld <= v2 && f2;
            if (v2 && f2) begin
                edge_cnt <= cnt;
                cnt      <= '0;
            end else if (v2 && res > thresh) begin
                cnt <= cnt + 32'd1;
            end
        end
    end
`endif
endmodule
